led_scan_driver: RTL and testbench

Parametrised time-multiplexed seven-segment display scanner; the successor to the fixed three-digit LED driver. Drives DIGITS hex digits with per-digit blanking and decimal points, anti-ghosting dead time between digits, tear-free frame-synchronous updates via a load strobe, and optional leading-zero blanking. Sits between the datapath (counters, registers to be displayed) and the board's common-anode display pins.

---
 rtl/led_scan_driver.sv | 206 ++++++++++++++++++++
 tb/tb_led_scan_driver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_driver.sv
// Time-multiplexed seven-segment scanner with dead time between digits and frame-synchronous loads.
// Define LED_SCAN_LZB_EN to enable leading-zero blanking.
module led_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame,
    output logic                  pending
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic {
        SHOW,
        DEAD
    } state_t;

    state_t                 state, state_n;
    logic [PW-1:0]          presc, presc_n;
    logic [DW-1:0]          dead_cnt, dead_cnt_n;
    logic [IW-1:0]          idx, idx_n;
    logic [4*DIGITS-1:0]    shadow_digits, shadow_digits_n;
    logic [DIGITS-1:0]      shadow_dp, shadow_dp_n;
    logic [DIGITS-1:0]      shadow_blank, shadow_blank_n;
    logic [4*DIGITS-1:0]    disp_digits, disp_digits_n;
    logic [DIGITS-1:0]      disp_dp, disp_dp_n;
    logic [DIGITS-1:0]      disp_blank, disp_blank_n;
    logic                   pending_n;
    logic                   wrap;

    logic [DIGITS-1:0]      lz_n;
    logic [3:0]             nib_n;
    logic [6:0]             seg_n;
    logic                   dp_n;
    logic [DIGITS-1:0]      an_n;

    function automatic logic [6:0] hex7(input logic [3:0] value);
        logic [6:0] glyph;
        case (value)
            4'h0:    glyph = 7'h40;
            4'h1:    glyph = 7'h79;
            4'h2:    glyph = 7'h24;
            4'h3:    glyph = 7'h30;
            4'h4:    glyph = 7'h19;
            4'h5:    glyph = 7'h12;
            4'h6:    glyph = 7'h02;
            4'h7:    glyph = 7'h78;
            4'h8:    glyph = 7'h00;
            4'h9:    glyph = 7'h10;
            4'hA:    glyph = 7'h08;
            4'hB:    glyph = 7'h03;
            4'hC:    glyph = 7'h46;
            4'hD:    glyph = 7'h21;
            4'hE:    glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
        return glyph;
    endfunction

    always_comb begin
        state_n         = state;
        presc_n         = presc;
        dead_cnt_n      = dead_cnt;
        idx_n           = idx;
        wrap            = 1'b0;
        shadow_digits_n = shadow_digits;
        shadow_dp_n     = shadow_dp;
        shadow_blank_n  = shadow_blank;
        disp_digits_n   = disp_digits;
        disp_dp_n       = disp_dp;
        disp_blank_n    = disp_blank;
        pending_n       = pending;

        case (state)
            SHOW: begin
                if (presc == PRESC_LAST) begin
                    presc_n = '0;
                    state_n = DEAD;
                end else begin
                    presc_n = presc + PW'(1);
                end
            end
            default: begin
                if (dead_cnt == DEAD_LAST) begin
                    dead_cnt_n = '0;
                    state_n    = SHOW;
                    if (idx == IDX_LAST) begin
                        idx_n = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end else begin
                    dead_cnt_n = dead_cnt + DW'(1);
                end
            end
        endcase

        if (load) begin
            shadow_digits_n = digits;
            shadow_dp_n     = dp_in;
            shadow_blank_n  = blank_in;
            pending_n       = 1'b1;
        end

        // A load landing on the wrap edge goes straight to the display so it is not held back a frame.
        if (wrap) begin
            if (load) begin
                disp_digits_n = digits;
                disp_dp_n     = dp_in;
                disp_blank_n  = blank_in;
            end else if (pending) begin
                disp_digits_n = shadow_digits;
                disp_dp_n     = shadow_dp;
                disp_blank_n  = shadow_blank;
            end
            pending_n = 1'b0;
        end
    end

`ifdef LED_SCAN_LZB_EN
    logic zero_run;

    // A digit is a leading zero when it and every digit above it are zero and it has no dp lit.
    always_comb begin
        lz_n     = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run & (disp_digits_n[4*i +: 4] == 4'h0);
            lz_n[i]  = zero_run & ~disp_dp_n[i];
        end
    end
`else
    always_comb begin
        lz_n = '0;
    end
`endif

    always_comb begin
        an_n  = '1;
        seg_n = 7'h7F;
        dp_n  = 1'b1;
        nib_n = disp_digits_n[4*idx_n +: 4];
        if (state_n == SHOW) begin
            an_n[idx_n] = 1'b0;
            if (!(disp_blank_n[idx_n] | lz_n[idx_n])) begin
                seg_n = hex7(nib_n);
                dp_n  = ~disp_dp_n[idx_n];
            end
        end
    end

    // Outputs are decoded from next state and registered alongside it, so pins change with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= DEAD;
            presc         <= '0;
            dead_cnt      <= '0;
            idx           <= IDX_LAST;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            shadow_blank  <= '0;
            disp_digits   <= '0;
            disp_dp       <= '0;
            disp_blank    <= '0;
            pending       <= 1'b0;
            frame         <= 1'b0;
            seg           <= 7'h7F;
            dp            <= 1'b1;
            an            <= '1;
        end else begin
            state         <= state_n;
            presc         <= presc_n;
            dead_cnt      <= dead_cnt_n;
            idx           <= idx_n;
            shadow_digits <= shadow_digits_n;
            shadow_dp     <= shadow_dp_n;
            shadow_blank  <= shadow_blank_n;
            disp_digits   <= disp_digits_n;
            disp_dp       <= disp_dp_n;
            disp_blank    <= disp_blank_n;
            pending       <= pending_n;
            frame         <= wrap;
            seg           <= seg_n;
            dp            <= dp_n;
            an            <= an_n;
        end
    end

endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver with DIGITS=4, CLK_DIV=8, DEAD_CYCLES=2 (40-cycle frame).
module tb_led_scan_driver;

    localparam int DIGITS      = 4;
    localparam int CLK_DIV     = 8;
    localparam int DEAD_CYCLES = 2;
    localparam int SLOT        = CLK_DIV + DEAD_CYCLES;
    localparam int FRAME       = DIGITS * SLOT;

    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame;
    logic        pending;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    led_scan_driver #(
        .DIGITS      (DIGITS),
        .CLK_DIV     (CLK_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .digits   (digits),
        .dp_in    (dp_in),
        .blank_in (blank_in),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .frame    (frame),
        .pending  (pending)
    );

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] dv, input logic [3:0] dpv,
                                 input logic [3:0] blv);
        load     = ld;
        digits   = dv;
        dp_in    = dpv;
        blank_in = blv;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Walks one full frame starting at the frame-pulse cycle; optionally pulses load at one step.
    task automatic scanFrame(input string name, input logic [27:0] segs, input logic [3:0] dps,
                             input int loadStep, input logic [15:0] ldDigits,
                             input logic [3:0] ldDp, input logic [3:0] ldBlank);
        for (int s = 0; s < FRAME; s++) begin
            int         d;
            int         c;
            logic [3:0] expAn;
            logic [6:0] expSeg;
            logic       expDp;
            d = s / SLOT;
            c = s % SLOT;
            if (c < CLK_DIV) begin
                expAn  = ~(4'b0001 << d);
                expSeg = segs[7*d +: 7];
                expDp  = dps[d];
            end else begin
                expAn  = 4'hF;
                expSeg = 7'h7F;
                expDp  = 1'b1;
            end
            checkOutput($sformatf("%s_s%0d_an", name, s), an, expAn);
            checkOutput($sformatf("%s_s%0d_seg", name, s), seg, expSeg);
            checkOutput($sformatf("%s_s%0d_dp", name, s), dp, expDp);
            checkOutput($sformatf("%s_s%0d_frame", name, s), frame, (s == 0) ? 1 : 0);
            if (s == loadStep) begin
                applyStimulus(1'b1, ldDigits, ldDp, ldBlank);
            end
            tick();
            if (s == loadStep) begin
                applyStimulus(1'b0, ldDigits, ldDp, ldBlank);
                if (s < FRAME - 1) begin
                    checkOutput($sformatf("%s_pending_after_load", name), pending, 1);
                end
            end
        end
    endtask

    initial begin
        int         ghost;
        int         badDark;
        int         darkRun;
        int         darkRuns;
        int         frames;
        logic [6:0] digit3Seg;

        reset = 1'b1;
        applyStimulus(1'b0, 16'h0000, 4'h0, 4'h0);
        repeat (3) tick();
        checkOutput("reset_an", an, 4'hF);
        checkOutput("reset_seg", seg, 7'h7F);
        checkOutput("reset_dp", dp, 1);
        checkOutput("reset_frame", frame, 0);
        checkOutput("reset_pending", pending, 0);

        reset = 1'b0;
        applyStimulus(1'b1, 16'h1208, 4'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 16'h1208, 4'h0, 4'h0);
        checkOutput("startup_dark1_an", an, 4'hF);
        checkOutput("startup_pending", pending, 1);
        checkOutput("startup_dark1_frame", frame, 0);
        tick();
        checkOutput("startup_first_frame", frame, 1);
        checkOutput("startup_pending_cleared", pending, 0);

        scanFrame("f1208", {7'h79, 7'h24, 7'h40, 7'h00}, 4'hF, -1, 16'h0, 4'h0, 4'h0);

        ghost    = 0;
        badDark  = 0;
        darkRun  = 0;
        darkRuns = 0;
        frames   = 0;
        for (int i = 0; i < 10 * FRAME; i++) begin
            if ($countones(~an) > 1) ghost++;
            if (an == 4'hF) begin
                if (darkRun == 0) darkRuns++;
                darkRun++;
            end else begin
                if (darkRun != 0 && darkRun != DEAD_CYCLES) badDark++;
                darkRun = 0;
            end
            if (frame) frames++;
            tick();
        end
        checkOutput("ghost_multi_anode", ghost, 0);
        checkOutput("ghost_dark_len", badDark, 0);
        checkOutput("ghost_dark_runs", darkRuns, 40);
        checkOutput("ghost_frame_count", frames, 10);

        scanFrame("tear", {7'h79, 7'h24, 7'h40, 7'h00}, 4'hF, 15, 16'hABCD, 4'h0, 4'h0);
        checkOutput("tear_pending_cleared", pending, 0);

        scanFrame("fabcd", {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF, FRAME - 1, 16'h5555, 4'h0, 4'h0);
        checkOutput("wrapload_pending", pending, 0);

        scanFrame("f5555", {7'h12, 7'h12, 7'h12, 7'h12}, 4'hF, 15, 16'h0042, 4'b0001, 4'b0100);
        checkOutput("blank_pending_cleared", pending, 0);

`ifdef LED_SCAN_LZB_EN
        digit3Seg = 7'h7F;
`else
        digit3Seg = 7'h40;
`endif
        scanFrame("fblank", {digit3Seg, 7'h7F, 7'h19, 7'h24}, 4'b1110, -1, 16'h0, 4'h0, 4'h0);

        repeat (2) tick();
        applyStimulus(1'b1, 16'hFFFF, 4'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 16'hFFFF, 4'h0, 4'h0);
        checkOutput("midreset_pending_before", pending, 1);
        repeat (19) tick();
        checkOutput("midreset_digit2_lit", an, 4'b1011);
        reset = 1'b1;
        tick();
        checkOutput("midreset_an", an, 4'hF);
        checkOutput("midreset_seg", seg, 7'h7F);
        checkOutput("midreset_dp", dp, 1);
        checkOutput("midreset_pending", pending, 0);
        reset = 1'b0;
        tick();
        checkOutput("postreset_dark_an", an, 4'hF);
        tick();
        checkOutput("postreset_frame", frame, 1);
        checkOutput("postreset_an", an, 4'b1110);
        checkOutput("postreset_seg_zero", seg, 7'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
